cell_tt_sequencer: RTL and testbench

CELL_TT_SEQUENCER -- requirements
Module: cell_tt_sequencer

---
 rtl/cell_tt_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cell_tt_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cell_tt_sequencer.sv
// -----------------------------------------------------------------------------
// cell_tt_sequencer
// Walks every input pattern of a combinational cell under test. Each pattern is
// held for SETTLE cycles, then ZN is sampled once and compared against the
// expected truth table that was latched at start.
//
// Ports
//   CK        clock, rising edge
//   RN        asynchronous active-low reset
//   start     single-cycle request for one exhaustive pass (ignored unless idle)
//   tt_expect expected ZN per pattern, bit k for pattern k
//   ZN        output of the cell under test
//   A         pattern driven to the cell (bit 0 -> A1)
//   busy      high while a pass is running
//   done      one-cycle pulse at the end of a pass
//   pass      last completed pass had no mismatches
//   err_cnt   mismatch count of the current or last pass
//   fail_vec  bit k set when pattern k mismatched
// -----------------------------------------------------------------------------
module cell_tt_sequencer #(
   parameter int unsigned N_IN   = 3,
   parameter int unsigned SETTLE = 2
) (
   input  logic                     CK,
   input  logic                     RN,
   input  logic                     start,
   input  logic [(1<<N_IN)-1:0]     tt_expect,
   input  logic                     ZN,
   output logic [N_IN-1:0]          A,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [N_IN:0]            err_cnt,
   output logic [(1<<N_IN)-1:0]     fail_vec
);

   localparam int unsigned A_W   = N_IN;
   localparam int unsigned NPAT  = 1 << N_IN;
   localparam int unsigned E_W   = N_IN + 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [A_W-1:0]    a_q, a_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NPAT-1:0]   exp_q, exp_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [E_W-1:0]    err_q, err_d;
   logic [NPAT-1:0]   fail_q, fail_d;

   // State and output registers
   always_ff @(posedge CK or negedge RN) begin
      if (!RN) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         cnt_q   <= '0;
         exp_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         fail_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         cnt_q   <= cnt_d;
         exp_q   <= exp_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      cnt_d   = cnt_q;
      exp_d   = exp_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;
      err_d   = err_q;
      fail_d  = fail_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               exp_d   = tt_expect;
               a_d     = '0;
               cnt_d   = '0;
               err_d   = '0;
               fail_d  = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE - 1)) begin
               cnt_d   = '0;
               state_d = ST_SAMPLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_SAMPLE: begin
            // An X/Z on ZN makes the equality unknown and falls into the
            // mismatch branch.
            if (ZN == exp_q[a_q]) begin
               err_d = err_q;
            end else begin
               if (err_q != E_W'(NPAT)) begin
                  err_d = err_q + E_W'(1);
               end
               fail_d[a_q] = 1'b1;
            end

            if (a_q == {A_W{1'b1}}) begin
               // Registered done/busy/pass take effect in the DONE cycle.
               state_d = ST_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               pass_d  = (err_d == '0);
            end else begin
               a_d     = a_q + A_W'(1);
               state_d = ST_SETTLE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign A        = a_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_cnt  = err_q;
   assign fail_vec = fail_q;

endmodule

// File: tb/tb_cell_tt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cell_tt_sequencer
// Two sequencer instances (N_IN=3/SETTLE=2 and N_IN=1/SETTLE=1). The cell
// under test for the first instance is a lookup table of 4-state values; the
// expected results of every pass are computed from that table and the latched
// expected truth table.
// -----------------------------------------------------------------------------
module tb_cell_tt_sequencer;

   localparam int unsigned N1 = 3;
   localparam int unsigned S1 = 2;
   localparam int unsigned P1 = 8;
   localparam int unsigned N2 = 1;
   localparam int unsigned S2 = 1;
   localparam int unsigned P2 = 2;

   logic CK = 1'b0;
   logic RN;
   always #5 CK = ~CK;

   logic              start1, start2;
   logic [P1-1:0]     tte1;
   logic [P2-1:0]     tte2;
   logic              zn1, zn2;
   logic [N1-1:0]     a1;
   logic [N2-1:0]     a2;
   logic              busy1, done1, pass1, busy2, done2, pass2;
   logic [N1:0]       err1;
   logic [N2:0]       err2;
   logic [P1-1:0]     fail1;
   logic [P2-1:0]     fail2;

   logic zn_tab [P1];

   assign zn1 = zn_tab[a1];
   assign zn2 = a2[0];

   int checks = 0;
   int errors = 0;

   cell_tt_sequencer #(.N_IN(N1), .SETTLE(S1)) dut1 (
      .CK(CK), .RN(RN), .start(start1), .tt_expect(tte1), .ZN(zn1),
      .A(a1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fail1)
   );

   cell_tt_sequencer #(.N_IN(N2), .SETTLE(S2)) dut2 (
      .CK(CK), .RN(RN), .start(start2), .tt_expect(tte2), .ZN(zn2),
      .A(a2), .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err2), .fail_vec(fail2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_or_table();
      for (int k = 0; k < int'(P1); k++) zn_tab[k] = (k != 0);
   endtask

   // One pass on instance 1; the expected results come from the cell table.
   task automatic run1(input string tag, input logic [P1-1:0] expv,
                       input int stray_at, input logic [P1-1:0] mid_exp);
      int            exp_err;
      logic [P1-1:0] exp_fail;
      int            cyc;
      bit            seen;
      exp_err  = 0;
      exp_fail = '0;
      for (int k = 0; k < int'(P1); k++) begin
         if (zn_tab[k] !== expv[k]) begin
            exp_err++;
            exp_fail[k] = 1'b1;
         end
      end

      @(posedge CK); #1;
      tte1   = expv;
      start1 = 1'b1;
      cyc    = 0;
      seen   = 1'b0;
      while (!seen && cyc < 200) begin
         @(posedge CK); cyc++; #1;
         start1 = (cyc == stray_at);
         if (cyc == 3) tte1 = mid_exp;
         if (done1 === 1'b1) begin
            seen = 1'b1;
         end else if (cyc <= int'(P1 * (S1 + 1))) begin
            chk({tag, "_busy"}, 32'(busy1), 32'd1);
            chk({tag, "_A"}, 32'(a1), 32'((cyc - 1) / int'(S1 + 1)));
         end
      end
      chk({tag, "_latency"}, 32'(cyc), 32'(P1 * (S1 + 1) + 1));
      chk({tag, "_busy_done"}, 32'(busy1), 32'd0);
      chk({tag, "_pass"}, 32'(pass1), 32'(exp_err == 0));
      chk({tag, "_err"}, 32'(err1), 32'(exp_err));
      chk({tag, "_fail"}, 32'(fail1), 32'(exp_fail));
      chk({tag, "_A_final"}, 32'(a1), 32'(P1 - 1));

      // start during the DONE cycle must be ignored
      start1 = 1'b1;
      @(posedge CK); #1;
      start1 = 1'b0;
      chk({tag, "_done_pulse"}, 32'(done1), 32'd0);
      @(posedge CK); #1;
      chk({tag, "_start_in_done"}, 32'(busy1), 32'd0);
      chk({tag, "_err_hold"}, 32'(err1), 32'(exp_err));
      chk({tag, "_fail_hold"}, 32'(fail1), 32'(exp_fail));
      chk({tag, "_pass_hold"}, 32'(pass1), 32'(exp_err == 0));
      chk({tag, "_A_hold"}, 32'(a1), 32'(P1 - 1));
   endtask

   initial begin
      int  cyc;
      bit  seen;
      bit  bad;
      RN     = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      tte1   = '0;
      tte2   = '0;
      set_or_table();

      // Reset state
      #12;
      chk("rst_A1", 32'(a1), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      chk("rst_done1", 32'(done1), 32'd0);
      chk("rst_pass1", 32'(pass1), 32'd0);
      chk("rst_err1", 32'(err1), 32'd0);
      chk("rst_fail1", 32'(fail1), 32'd0);
      chk("rst_A2", 32'(a2), 32'd0);
      chk("rst_busy2", 32'(busy2), 32'd0);
      @(posedge CK); #1;
      RN = 1'b1;
      repeat (2) @(posedge CK);

      // Ideal OR cell against 8'hFE
      run1("or", 8'hFE, 0, 8'hFE);

      // Stuck-at-0 cell
      for (int k = 0; k < int'(P1); k++) zn_tab[k] = 1'b0;
      run1("stuck0", 8'hFE, 0, 8'hFE);

      // OR cell with X during pattern 3
      set_or_table();
      zn_tab[3] = 1'bx;
      run1("xpat3", 8'hFE, 0, 8'hFE);

      // Extra start at cycle 10 and tt_expect change mid-pass
      set_or_table();
      run1("stray", 8'hFE, 10, 8'h00);

      // Random tables
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < int'(P1); k++) zn_tab[k] = 1'($urandom_range(0, 1));
         run1("rand", P1'($urandom), 0, P1'($urandom));
      end

      // Reset during pattern 4 of a failing pass
      for (int k = 0; k < int'(P1); k++) zn_tab[k] = 1'b0;
      @(posedge CK); #1;
      tte1   = 8'hFE;
      start1 = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(posedge CK); #1;
         start1 = 1'b0;
      end
      chk("pre_rst_A", 32'(a1), 32'd4);
      chk("pre_rst_err", 32'(err1), 32'd3);
      #2 RN = 1'b0;
      #1;
      chk("mid_rst_A", 32'(a1), 32'd0);
      chk("mid_rst_busy", 32'(busy1), 32'd0);
      chk("mid_rst_done", 32'(done1), 32'd0);
      chk("mid_rst_pass", 32'(pass1), 32'd0);
      chk("mid_rst_err", 32'(err1), 32'd0);
      chk("mid_rst_fail", 32'(fail1), 32'd0);
      @(posedge CK); #1;
      RN  = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(posedge CK); #1;
         if (done1 !== 1'b0 || busy1 !== 1'b0) bad = 1'b1;
      end
      chk("post_rst_idle", 32'(bad), 32'd0);
      set_or_table();
      run1("after_rst", 8'hFE, 0, 8'hFE);

      // Instance 2: N_IN=1, SETTLE=1, ZN=A
      @(posedge CK); #1;
      tte2   = 2'b10;
      start2 = 1'b1;
      cyc    = 0;
      seen   = 1'b0;
      while (!seen && cyc < 100) begin
         @(posedge CK); cyc++; #1;
         start2 = 1'b0;
         if (done2 === 1'b1) seen = 1'b1;
      end
      chk("n1_latency", 32'(cyc), 32'(P2 * (S2 + 1) + 1));
      chk("n1_pass", 32'(pass2), 32'd1);
      chk("n1_err", 32'(err2), 32'd0);
      chk("n1_fail", 32'(fail2), 32'd0);
      chk("n1_A", 32'(a2), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
